// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM states, word size and
// the default reset fetch address.
package cpu_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam int          QUEUE_DEPTH      = 2;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // Sequential word address; wraps modulo 2^64.
  function automatic logic [63:0] next_word(input logic [63:0] pc);
    return pc + 64'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO carrying {pc, instr}; flush empties it at once,
// and a push into a full queue is accepted only when a pop frees a slot.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [63:0]        push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [63:0]        head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic [63:0]        pc_q    [QUEUE_DEPTH];
  logic [63:0]        pc_d    [QUEUE_DEPTH];
  logic [INSTR_W-1:0] instr_q [QUEUE_DEPTH];
  logic [INSTR_W-1:0] instr_d [QUEUE_DEPTH];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_pop, do_push;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'(QUEUE_DEPTH)) || do_pop);
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        pc_d[wr_ptr_q]    = push_pc;
        instr_d[wr_ptr_q] = push_instr;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_instr = instr_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request channel, redirect
// handling with stale-response discard, and a 2-entry queue feeding IF/ID.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_id,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [63:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               valid_if,
  output logic [INSTR_W-1:0] instr_if,
  output logic [63:0]        pc_if,
  output logic [63:0]        BLT_if
);

  fetch_state_t state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic         outstanding_q, outstanding_d;
  logic [63:0]  last_pc_q, last_pc_d;
  logic [63:0]  last_blt_q, last_blt_d;

  logic               q_push, q_pop, q_flush;
  logic [1:0]         q_count;
  logic               q_head_valid;
  logic [63:0]        q_head_pc;
  logic [INSTR_W-1:0] q_head_instr;
  logic               req_accept;

  fetch_queue #(.INSTR_W(INSTR_W)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_pc    (req_pc_q),
    .push_instr (imem_rsp_data),
    .pop        (q_pop),
    .flush      (q_flush),
    .count      (q_count),
    .head_valid (q_head_valid),
    .head_pc    (q_head_pc),
    .head_instr (q_head_instr)
  );

  // A redirect withdraws any request this cycle so nothing old is accepted.
  assign imem_req_valid = reset && (state_q == RUN) && !outstanding_q && !redirect_valid
                          && (({1'b0, q_count} + {2'b0, outstanding_q}) < 3'd2);
  assign imem_req_addr  = fetch_pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    q_push        = 1'b0;
    q_flush       = redirect_valid;
    q_pop         = q_head_valid && !stall_id && !redirect_valid;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      if (outstanding_q && !imem_rsp_valid) begin
        state_d = DISCARD;
      end else begin
        // Any response landing now belongs to the old path and is dropped.
        outstanding_d = 1'b0;
        state_d       = RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (imem_rsp_valid && outstanding_q) begin
            q_push        = 1'b1;
            outstanding_d = 1'b0;
          end
          if (req_accept) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = next_word(fetch_pc_q);
          end
        end
        DISCARD: begin
          if (imem_rsp_valid) begin
            outstanding_d = 1'b0;
            state_d       = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    last_pc_d  = q_head_valid ? q_head_pc : last_pc_q;
    last_blt_d = q_head_valid ? next_word(q_head_pc) : last_blt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      last_pc_q     <= '0;
      last_blt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      last_pc_q     <= last_pc_d;
      last_blt_q    <= last_blt_d;
    end
  end

  assign valid_if = q_head_valid;
  assign instr_if = q_head_valid ? q_head_instr : '0;
  assign pc_if    = q_head_valid ? q_head_pc : last_pc_q;
  assign BLT_if   = q_head_valid ? next_word(q_head_pc) : last_blt_q;

endmodule
